cs_scheduler: RTL and testbench



---
 rtl/cs_scheduler_if.sv | 35 +++
 rtl/cs_scheduler.sv | 116 +++++++++++
 tb/tb_cs_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cs_scheduler_if.sv
// Signal bundle between the clip/split scheduler and its assembler, bounds check,
// clipper and rasterizer neighbours. The scheduler is the master side.
interface cs_scheduler_if;
  logic        enable;
  logic        texel_ready;
  logic        texel_read;
  logic        latch_en;
  logic        out_of_bounds;
  logic        fully_outside;
  logic        clip_start;
  logic        clip_valid;
  logic        clip_last;
  logic        clip_empty;
  logic        clip_next;
  logic        out_sel;
  logic        triangle_ready;
  logic        triangle_read;
  logic        busy;
  logic [15:0] tri_in_count;
  logic [15:0] tri_drop_count;

  modport master (
    input  enable, texel_ready, out_of_bounds, fully_outside,
           clip_valid, clip_last, clip_empty, triangle_read,
    output texel_read, latch_en, clip_start, clip_next, out_sel,
           triangle_ready, busy, tri_in_count, tri_drop_count
  );

  modport slave (
    output enable, texel_ready, out_of_bounds, fully_outside,
           clip_valid, clip_last, clip_empty, triangle_read,
    input  texel_read, latch_en, clip_start, clip_next, out_sel,
           triangle_ready, busy, tri_in_count, tri_drop_count
  );
endinterface

// File: rtl/cs_scheduler.sv
// Clip/split stage sequencer: fetches triangles, routes them to the rasterizer,
// the clipper or the bin, and keeps saturating fetch/drop statistics.
module cs_scheduler (
  input  logic           clk,
  input  logic           rst,
  cs_scheduler_if.master bus
);
  // state      | meaning
  // IDLE       | waiting for texel_ready & enable
  // FETCH      | consume assembler triangle into the holding register
  // CHECK      | evaluate bounds verdict of the held triangle
  // PASS       | present held triangle to the rasterizer
  // CLIP_START | kick the clipper on the held triangle
  // CLIP_WAIT  | wait for a clipper triangle or an empty verdict
  // CLIP_OUT   | present clipper triangle to the rasterizer
  // DROP       | count the discarded triangle
  typedef enum logic [2:0] {
    IDLE, FETCH, CHECK, PASS, CLIP_START, CLIP_WAIT, CLIP_OUT, DROP
  } state_t;

  state_t      state, state_nxt;
  logic        next_pend, next_pend_nxt;
  logic        last_q, last_nxt;
  logic        out_sel_q, out_sel_nxt;
  logic [15:0] in_cnt, drop_cnt;
  logic        fetch_go;
  logic        texel_read_c, clip_start_c, clip_next_c;

  assign fetch_go = bus.texel_ready & bus.enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      next_pend <= 1'b0;
      last_q    <= 1'b0;
      out_sel_q <= 1'b0;
      in_cnt    <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      state     <= state_nxt;
      next_pend <= next_pend_nxt;
      last_q    <= last_nxt;
      out_sel_q <= out_sel_nxt;
      if (state == FETCH && in_cnt != 16'hFFFF)
        in_cnt <= in_cnt + 16'd1;
      if (state == DROP && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    next_pend_nxt = 1'b0;
    last_nxt      = last_q;
    out_sel_nxt   = out_sel_q;
    texel_read_c  = 1'b0;
    clip_start_c  = 1'b0;
    clip_next_c   = 1'b0;
    case (state)
      IDLE: if (fetch_go) state_nxt = FETCH;
      FETCH: begin
        texel_read_c = 1'b1;
        state_nxt    = CHECK;
      end
      CHECK: begin
        if (bus.fully_outside) begin
          state_nxt = DROP;
        end else if (bus.out_of_bounds) begin
          state_nxt   = CLIP_START;
          out_sel_nxt = 1'b1;
        end else begin
          state_nxt   = PASS;
          out_sel_nxt = 1'b0;
        end
      end
      PASS: if (bus.triangle_read) state_nxt = fetch_go ? FETCH : IDLE;
      CLIP_START: begin
        clip_start_c = 1'b1;
        state_nxt    = CLIP_WAIT;
      end
      CLIP_WAIT: begin
        // The clipper still shows the previous triangle while clip_next is out.
        if (next_pend) begin
          clip_next_c = 1'b1;
        end else if (bus.clip_valid) begin
          state_nxt = CLIP_OUT;
          last_nxt  = bus.clip_last;
        end else if (bus.clip_empty) begin
          state_nxt = DROP;
        end
      end
      CLIP_OUT: begin
        if (bus.triangle_read) begin
          if (last_q) begin
            state_nxt = IDLE;
          end else begin
            state_nxt     = CLIP_WAIT;
            next_pend_nxt = 1'b1;
          end
        end
      end
      DROP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.texel_read     = texel_read_c;
  assign bus.latch_en       = texel_read_c;
  assign bus.clip_start     = clip_start_c;
  assign bus.clip_next      = clip_next_c;
  assign bus.out_sel        = out_sel_q;
  assign bus.triangle_ready = (state == PASS) || (state == CLIP_OUT);
  assign bus.busy           = (state != IDLE);
  assign bus.tri_in_count   = in_cnt;
  assign bus.tri_drop_count = drop_cnt;
endmodule

// File: tb/tb_cs_scheduler.sv
// Bench for cs_scheduler: assembler, clipper and rasterizer agents with randomized
// timing, checked against a per-triangle outcome model with saturating counters.
module tb_cs_scheduler;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   model_in   = 0;
  int   model_drop = 0;

  cs_scheduler_if bus ();

  cs_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable        = 1'b1;
    bus.texel_ready   = 1'b0;
    bus.out_of_bounds = 1'b0;
    bus.fully_outside = 1'b0;
    bus.clip_valid    = 1'b0;
    bus.clip_last     = 1'b0;
    bus.clip_empty    = 1'b0;
    bus.triangle_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.texel_read, bus.latch_en, bus.clip_start, bus.clip_next,
         bus.triangle_ready, bus.busy, bus.out_sel} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000000", {bus.texel_read, bus.latch_en,
               bus.clip_start, bus.clip_next, bus.triangle_ready, bus.busy, bus.out_sel});
    end
    n_tests++;
    if (bus.tri_in_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_in_count: got %0d want 0", bus.tri_in_count);
    end
    n_tests++;
    if (bus.tri_drop_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_drop_count: got %0d want 0", bus.tri_drop_count);
    end
    model_in   = 0;
    model_drop = 0;
  endtask

  task automatic test_pass_latency();
    bus.texel_ready   = 1'b1;
    bus.triangle_read = 1'b1;
    tick();
    n_tests++;
    if (bus.texel_read !== 1'b1 || bus.latch_en !== 1'b1) begin
      n_fail++; $display("FAIL lat_texel_read: got %b%b want 11", bus.texel_read, bus.latch_en);
    end
    bus.texel_ready = 1'b0;
    model_in = sat(model_in);
    tick();
    n_tests++;
    if (bus.triangle_ready !== 1'b0) begin
      n_fail++; $display("FAIL lat_ready_early: got %b want 0", bus.triangle_ready);
    end
    n_tests++;
    if (bus.tri_in_count !== 16'(model_in)) begin
      n_fail++; $display("FAIL lat_in_count: got %0d want %0d", bus.tri_in_count, model_in);
    end
    tick();
    n_tests++;
    if (bus.triangle_ready !== 1'b1 || bus.out_sel !== 1'b0) begin
      n_fail++; $display("FAIL lat_ready_cycle3: got ready=%b sel=%b want ready=1 sel=0",
                         bus.triangle_ready, bus.out_sel);
    end
    tick();
    n_tests++;
    if (bus.triangle_ready !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL lat_back_idle: got ready=%b busy=%b want 0 0",
                         bus.triangle_ready, bus.busy);
    end
    n_tests++;
    if (bus.tri_drop_count !== 16'(model_drop)) begin
      n_fail++; $display("FAIL lat_drop_count: got %0d want %0d", bus.tri_drop_count, model_drop);
    end
    idle_inputs();
  endtask

  // kind: 0 pass, 1 cull, 2 clip with n_clip outputs (0 = clipped to empty)
  task automatic do_triangle(input int kind, input int n_clip, input bit conflict, input string tag);
    int  t_read = 0, eps = 0, nexts = 0, starts = 0, reads = 0;
    int  produced = 0, clip_wait = -1, rd_wait = 0, v_cyc = -1, b = 0;
    int  exp_eps, exp_nexts, exp_ready_cyc;
    bit  exp_sel, ep_open = 0, read_given = 0;
    exp_eps   = (kind == 0) ? 1 : (kind == 2) ? n_clip : 0;
    exp_nexts = (kind == 2 && n_clip > 0) ? n_clip - 1 : 0;
    exp_sel   = (kind == 2);
    bus.out_of_bounds = 1'($urandom_range(0, 1));
    bus.fully_outside = 1'($urandom_range(0, 1));
    bus.texel_ready   = 1'b1;
    while (bus.texel_read !== 1'b1 && b < 8) begin tick(); b++; end
    n_tests++;
    if (bus.texel_read !== 1'b1 || bus.latch_en !== 1'b1) begin
      n_fail++; $display("FAIL %s_fetch: got %b%b want 11", tag, bus.texel_read, bus.latch_en);
    end
    t_read = cyc;
    reads  = 1;
    model_in = sat(model_in);
    bus.texel_ready   = 1'b0;
    bus.fully_outside = (kind == 1);
    bus.out_of_bounds = (kind != 0);
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.texel_read === 1'b1) reads++;
      if (clip_wait == 0) begin
        if (n_clip == 0) begin
          bus.clip_empty = 1'b1;
        end else begin
          bus.clip_valid = 1'b1;
          bus.clip_last  = (produced == n_clip - 1);
          bus.clip_empty = conflict && (produced == 0);
        end
        produced++;
        v_cyc     = cyc;
        clip_wait = -1;
      end else if (clip_wait > 0) begin
        clip_wait--;
      end
      if (bus.clip_start === 1'b1) begin
        starts++;
        clip_wait = $urandom_range(0, 3);
        n_tests++;
        if (cyc != t_read + 2) begin
          n_fail++; $display("FAIL %s_clip_start_lat: got %0d want %0d", tag, cyc - t_read, 2);
        end
      end
      if (bus.clip_next === 1'b1) begin
        nexts++;
        clip_wait = $urandom_range(0, 3);
      end
      if (read_given) begin
        n_tests++;
        if (bus.triangle_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s_ready_drop: got %b want 0", tag, bus.triangle_ready);
        end
        read_given = 0;
        ep_open    = 0;
        bus.triangle_read = 1'b0;
        bus.clip_valid    = 1'b0;
        bus.clip_last     = 1'b0;
        bus.clip_empty    = 1'b0;
      end else if (bus.triangle_ready === 1'b1) begin
        if (!ep_open) begin
          ep_open = 1;
          eps++;
          rd_wait = $urandom_range(0, 3);
          exp_ready_cyc = (kind == 0) ? t_read + 2 : v_cyc + 1;
          n_tests++;
          if (cyc != exp_ready_cyc) begin
            n_fail++; $display("FAIL %s_ready_lat: got cycle %0d want %0d", tag, cyc, exp_ready_cyc);
          end
        end
        n_tests++;
        if (bus.out_sel !== exp_sel) begin
          n_fail++; $display("FAIL %s_out_sel: got %b want %b", tag, bus.out_sel, exp_sel);
        end
        if (rd_wait == 0) begin
          bus.triangle_read = 1'b1;
          read_given = 1;
        end else begin
          rd_wait--;
        end
      end else if (ep_open) begin
        n_tests++; n_fail++;
        $display("FAIL %s_ready_held: got 0 want 1 before read", tag);
        ep_open = 0;
      end
      if (bus.busy === 1'b0) break;
    end
    if (kind == 1 || (kind == 2 && n_clip == 0)) model_drop = sat(model_drop);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_return_idle: got busy=%b want 0", tag, bus.busy);
    end
    n_tests++;
    if (eps != exp_eps) begin
      n_fail++; $display("FAIL %s_episodes: got %0d want %0d", tag, eps, exp_eps);
    end
    n_tests++;
    if (starts != ((kind == 2) ? 1 : 0) || nexts != exp_nexts || reads != 1) begin
      n_fail++; $display("FAIL %s_pulses: got start=%0d next=%0d read=%0d want %0d %0d 1",
                         tag, starts, nexts, reads, (kind == 2) ? 1 : 0, exp_nexts);
    end
    n_tests++;
    if (bus.tri_in_count !== 16'(model_in) || bus.tri_drop_count !== 16'(model_drop)) begin
      n_fail++; $display("FAIL %s_counters: got in=%0d drop=%0d want in=%0d drop=%0d",
                         tag, bus.tri_in_count, bus.tri_drop_count, model_in, model_drop);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    int b = 0;
    bus.texel_ready = 1'b1;
    while (bus.texel_read !== 1'b1 && b < 8) begin tick(); b++; end
    model_in = sat(model_in);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (bus.triangle_ready !== 1'b1 || bus.texel_read !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: got ready=%b texel_read=%b want 1 0",
                           bus.triangle_ready, bus.texel_read);
      end
      tick();
    end
    bus.triangle_read = 1'b1;
    tick();
    n_tests++;
    if (bus.texel_read !== 1'b1 || bus.triangle_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_refetch: got texel_read=%b ready=%b want 1 0",
                         bus.texel_read, bus.triangle_ready);
    end
    model_in = sat(model_in);
    bus.texel_ready   = 1'b0;
    bus.triangle_read = 1'b0;
    tick();
    tick();
    bus.triangle_read = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.tri_in_count !== 16'(model_in)) begin
      n_fail++; $display("FAIL bp_end: got busy=%b in=%0d want 0 %0d", bus.busy, bus.tri_in_count, model_in);
    end
    idle_inputs();
  endtask

  task automatic test_enable_drop();
    int b = 0;
    bus.texel_ready = 1'b1;
    while (bus.texel_read !== 1'b1 && b < 8) begin tick(); b++; end
    model_in = sat(model_in);
    tick();
    tick();
    bus.enable = 1'b0;
    n_tests++;
    if (bus.triangle_ready !== 1'b1) begin
      n_fail++; $display("FAIL en_completes: got ready=%b want 1", bus.triangle_ready);
    end
    bus.triangle_read = 1'b1;
    tick();
    bus.triangle_read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (bus.texel_read !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL en_no_fetch: got texel_read=%b busy=%b want 0 0", bus.texel_read, bus.busy);
      end
      tick();
    end
    bus.enable = 1'b1;
    tick();
    n_tests++;
    if (bus.texel_read !== 1'b1) begin
      n_fail++; $display("FAIL en_resume: got texel_read=%b want 1", bus.texel_read);
    end
    model_in = sat(model_in);
    bus.texel_ready = 1'b0;
    tick();
    tick();
    bus.triangle_read = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int b = 0, prev;
    bus.texel_ready   = 1'b1;
    bus.triangle_read = 1'b1;
    while (bus.texel_read !== 1'b1 && b < 8) begin tick(); b++; end
    model_in = sat(model_in);
    prev = cyc;
    for (int i = 0; i < 3; i++) begin
      b = 0;
      do begin tick(); b++; end while (bus.texel_read !== 1'b1 && b < 8);
      model_in = sat(model_in);
      n_tests++;
      if (cyc - prev != 3) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 3", cyc - prev);
      end
      prev = cyc;
    end
    bus.texel_ready = 1'b0;
    tick();
    tick();
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.tri_in_count !== 16'(model_in)) begin
      n_fail++; $display("FAIL b2b_end: got busy=%b in=%0d want 0 %0d", bus.busy, bus.tri_in_count, model_in);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int kind, n;
    bit cf;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      n    = $urandom_range(0, 3);
      cf   = (n > 0) && ($urandom_range(0, 1) == 1);
      do_triangle(kind, n, cf, "rand");
    end
  endtask

  task automatic test_saturation();
    force dut.in_cnt = 16'hFFFE;
    #1;
    release dut.in_cnt;
    model_in = 65534;
    do_triangle(0, 0, 0, "sat_in_a");
    do_triangle(0, 0, 0, "sat_in_b");
    force dut.drop_cnt = 16'hFFFE;
    #1;
    release dut.drop_cnt;
    model_drop = 65534;
    do_triangle(1, 0, 0, "sat_drop_a");
    do_triangle(2, 0, 0, "sat_drop_b");
  endtask

  task automatic test_reset_mid();
    int b = 0;
    bus.texel_ready = 1'b1;
    while (bus.texel_read !== 1'b1 && b < 8) begin tick(); b++; end
    bus.texel_ready   = 1'b0;
    bus.out_of_bounds = 1'b1;
    tick();
    tick();
    bus.clip_valid = 1'b1;
    tick();
    tick();
    n_tests++;
    if (bus.triangle_ready !== 1'b1 || bus.out_sel !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_in_clip_out: got ready=%b sel=%b want 1 1", bus.triangle_ready, bus.out_sel);
    end
    rst = 1'b1;
    bus.triangle_read = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    n_tests++;
    if ({bus.texel_read, bus.latch_en, bus.clip_start, bus.clip_next,
         bus.triangle_ready, bus.busy, bus.out_sel} !== 7'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b want 0000000", {bus.texel_read, bus.latch_en,
               bus.clip_start, bus.clip_next, bus.triangle_ready, bus.busy, bus.out_sel});
    end
    n_tests++;
    if (bus.tri_in_count !== 16'd0 || bus.tri_drop_count !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_counters: got in=%0d drop=%0d want 0 0", bus.tri_in_count, bus.tri_drop_count);
    end
    model_in   = 0;
    model_drop = 0;
  endtask

  initial begin
    test_reset();
    test_pass_latency();
    do_triangle(1, 0, 0, "cull");
    do_triangle(2, 2, 0, "split2");
    do_triangle(2, 0, 0, "clip_empty");
    do_triangle(2, 2, 1, "conflict");
    test_backpressure();
    test_enable_drop();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid();
    do_triangle(0, 0, 0, "after_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
